// File: rtl/nmr_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : nmr_gen_pkg                                                 |
// | Purpose    : Shared widths, FSM state encoding and quarter-wave sine     |
// |              table generator for the NMR pulse generator.                |
// | Ports      : none (package)                                              |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package nmr_gen_pkg;

   localparam int LUT_ADDR_W = 10;                     // quarter-wave table index
   localparam int LUT_DEPTH  = 1 << LUT_ADDR_W;
   localparam int ADDR_W     = LUT_ADDR_W + 2;         // plus 2-bit quadrant
   localparam int PHASE_W    = 32;
   localparam int SINE_W     = 16;
   localparam int ENV_W      = 16;
   localparam int DAC_W      = 14;
   localparam int PIPE_LAT   = 3;
   localparam int SINE_PEAK  = 32767;
   // Keeps product bits [31:18]: the 16x17 product never exceeds 31 magnitude bits.
   localparam int PROD_SHIFT = 2 * SINE_W - DAC_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RAMP_UP   = 2'd1,
      ST_HOLD      = 2'd2,
      ST_RAMP_DOWN = 2'd3
   } gen_state_t;

   // Entry idx of the first quadrant: round(32767 * sin(idx * pi / 2048)).
   // Only ever called with constant arguments, so it folds to ROM contents.
   function automatic logic [SINE_W-1:0] quarter_sine(input int idx);
      real angle;
      angle = 3.14159265358979323846 * real'(idx) / real'(2 * LUT_DEPTH);
      return SINE_W'($rtoi(real'(SINE_PEAK) * $sin(angle) + 0.5));
   endfunction

endpackage
`default_nettype wire

// File: rtl/nmr_sine_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : nmr_sine_lut                                                |
// | Purpose    : Full-wave sine from a 1024-entry quarter-wave ROM using     |
// |              quadrant folding; one registered output stage.              |
// | Ports      : clk, rst (async, active-high)                               |
// |              addr [11:0]  phase address, [11:10] = quadrant              |
// |              sine [15:0]  signed sample, range +/-32767, 1 clk latency   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module nmr_sine_lut
   import nmr_gen_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        addr,
   output logic signed [SINE_W-1:0] sine
);

   logic [SINE_W-1:0]        rom [LUT_DEPTH];
   logic [1:0]               quadrant;
   logic [LUT_ADDR_W-1:0]    idx;
   logic [LUT_ADDR_W-1:0]    mirror_idx;
   logic [SINE_W-1:0]        magnitude;
   logic signed [SINE_W-1:0] folded;

   for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
      assign rom[i] = quarter_sine(i);
   end

   always_comb begin
      quadrant   = addr[ADDR_W-1 -: 2];
      idx        = addr[LUT_ADDR_W-1:0];
      // Odd quadrants run the table backwards: entry (1024 - idx).
      mirror_idx = LUT_ADDR_W'(0) - idx;
      magnitude  = '0;
      if (quadrant[0]) begin
         // idx 0 of an odd quadrant is the peak, one past the table end.
         if (idx == '0) begin
            magnitude = SINE_W'(SINE_PEAK);
         end else begin
            magnitude = rom[mirror_idx];
         end
      end else begin
         magnitude = rom[idx];
      end
      // Magnitude never exceeds 32767, so negation cannot reach -32768.
      folded = quadrant[1] ? -$signed(magnitude) : $signed(magnitude);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sine <= '0;
      end else begin
         sine <= folded;
      end
   end

endmodule
`default_nettype wire

// File: rtl/nmr_pulse_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : nmr_pulse_gen                                               |
// | Purpose    : NMR RF pulse generator: NCO phase accumulator, trapezoidal  |
// |              envelope FSM and 3-stage sine x envelope DAC pipeline.      |
// | Ports      : clk, rst (async, active-high), en_gen pulse request         |
// |              cfg_freq/cfg_phase [31:0], cfg_amplitude/cfg_ramp_step[15:0]|
// |              dac_data [13:0] signed sample, dac_valid, tx_gate,          |
// |              busy (not idle), done (1-cycle end-of-pulse strobe)         |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module nmr_pulse_gen
   import nmr_gen_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en_gen,
   input  logic [PHASE_W-1:0]       cfg_freq,
   input  logic [ENV_W-1:0]         cfg_amplitude,
   input  logic [ENV_W-1:0]         cfg_ramp_step,
   input  logic [PHASE_W-1:0]       cfg_phase,
   output logic signed [DAC_W-1:0]  dac_data,
   output logic                     dac_valid,
   output logic                     tx_gate,
   output logic                     busy,
   output logic                     done
);

   gen_state_t                   state, next_state;
   logic [PHASE_W-1:0]           phase_acc, freq_q, phase_q, phase_sum;
   logic [ENV_W-1:0]             amp_q, step_q, env, env_next;
   logic [ENV_W:0]               ramp_sum;
   logic                         latch_cfg, done_next;

   logic [ADDR_W-1:0]            s1_addr;
   logic [ENV_W-1:0]             s1_env, s2_env;
   logic                         s1_valid, s2_valid;
   logic signed [SINE_W-1:0]     s2_sine;
   logic signed [SINE_W+ENV_W:0] product;

   // ---------------- envelope FSM ----------------
   always_comb begin
      next_state = state;
      env_next   = env;
      latch_cfg  = 1'b0;
      done_next  = 1'b0;
      ramp_sum   = {1'b0, env} + {1'b0, step_q};   // 17-bit, cannot wrap
      case (state)
         ST_IDLE: begin
            if (en_gen) begin
               next_state = ST_RAMP_UP;
               latch_cfg  = 1'b1;
               // First envelope value is min(step, amp); a zero step means no ramp.
               if ((cfg_ramp_step == '0) || (cfg_ramp_step >= cfg_amplitude)) begin
                  env_next = cfg_amplitude;
               end else begin
                  env_next = cfg_ramp_step;
               end
            end
         end
         ST_RAMP_UP: begin
            // A dropped request wins over the ramp: descend from where we are.
            if (!en_gen) begin
               next_state = ST_RAMP_DOWN;
            end else if (ramp_sum >= {1'b0, amp_q}) begin
               env_next   = amp_q;
               next_state = ST_HOLD;
            end else begin
               env_next = ramp_sum[ENV_W-1:0];
            end
         end
         ST_HOLD: begin
            env_next = amp_q;
            if (!en_gen) begin
               next_state = ST_RAMP_DOWN;
            end
         end
         ST_RAMP_DOWN: begin
            if ((step_q == '0) || (env <= step_q)) begin
               env_next   = '0;
               next_state = ST_IDLE;
               done_next  = 1'b1;
            end else begin
               env_next = env - step_q;
            end
         end
         default: begin
            next_state = ST_IDLE;
            env_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         env       <= '0;
         done      <= 1'b0;
         phase_acc <= '0;
         freq_q    <= '0;
         phase_q   <= '0;
         amp_q     <= '0;
         step_q    <= '0;
      end else begin
         state <= next_state;
         env   <= env_next;
         done  <= done_next;
         if (latch_cfg) begin
            freq_q    <= cfg_freq;
            phase_q   <= cfg_phase;
            amp_q     <= cfg_amplitude;
            step_q    <= cfg_ramp_step;
            phase_acc <= '0;
         end else if (state != ST_IDLE) begin
            phase_acc <= phase_acc + freq_q;
         end
      end
   end

   assign busy = (state != ST_IDLE);

   // ---------------- sample pipeline ----------------
   assign phase_sum = phase_acc + phase_q;
   assign product   = s2_sine * $signed({1'b0, s2_env});

   nmr_sine_lut u_sine_lut (
      .clk  (clk),
      .rst  (rst),
      .addr (s1_addr),
      .sine (s2_sine)
   );

   // S1 address/envelope, S2 sine (inside the LUT) with env alongside,
   // S3 scaled output. Valid travels with the samples and gates them to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_addr   <= '0;
         s1_env    <= '0;
         s1_valid  <= 1'b0;
         s2_env    <= '0;
         s2_valid  <= 1'b0;
         dac_data  <= '0;
         dac_valid <= 1'b0;
      end else begin
         s1_addr   <= ADDR_W'(phase_sum >> (PHASE_W - ADDR_W));
         s1_env    <= env;
         s1_valid  <= busy;
         s2_env    <= s1_env;
         s2_valid  <= s1_valid;
         dac_data  <= s2_valid ? DAC_W'(product >>> PROD_SHIFT) : '0;
         dac_valid <= s2_valid;
      end
   end

   assign tx_gate = dac_valid;

endmodule
`default_nettype wire

// File: doc/nmr_pulse_gen.md
NMR_PULSE_GEN -- requirements
Module: nmr_pulse_gen

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 en_gen  in  1  pulse request level from the acquisition FSM.
REQ-005 cfg_freq  in  32  phase increment per clk; f = cfg_freq*fclk/2^32.
REQ-006 cfg_amplitude  in  16  unsigned peak envelope.
REQ-007 cfg_ramp_step  in  16  unsigned envelope increment per clk; 0 = no ramp.
REQ-008 cfg_phase  in  32  phase offset added to the accumulator.
REQ-009 dac_data  out  14  signed two's-complement DAC sample.
REQ-010 dac_valid  out  1  dac_data carries pulse samples.
REQ-011 tx_gate  out  1  amplifier unblank; equals dac_valid.
REQ-012 busy  out  1  state is not IDLE.
REQ-013 done  out  1  one-cycle strobe at pulse end.

Function
REQ-014 FSM states SHALL be IDLE, RAMP_UP, HOLD and RAMP_DOWN.
REQ-015 IDLE with en_gen=1 SHALL go to RAMP_UP at the next edge and SHALL latch cfg_freq, cfg_amplitude, cfg_ramp_step and cfg_phase at that edge; config changes mid-pulse SHALL be ignored.
REQ-016 At the IDLE exit edge, phase_acc SHALL be 0 and env SHALL be min(step, amp); step 0 SHALL give env=amp.
REQ-017 RAMP_UP: env SHALL add step with a 17-bit sum; sum>=amp SHALL set env=amp and go to HOLD; en_gen=0 SHALL go to RAMP_DOWN with env unchanged.
REQ-018 HOLD: env=amp; en_gen=0 SHALL go to RAMP_DOWN.
REQ-019 RAMP_DOWN: env<=step or step=0 SHALL set env=0, go to IDLE and pulse done for one cycle; otherwise env SHALL be reduced by step; en_gen is ignored.
REQ-020 Re-assertion of en_gen in IDLE directly after done SHALL start a new pulse with phase_acc reset to 0.
REQ-021 phase_acc SHALL add the latched freq every non-IDLE cycle and wrap modulo 2^32.
REQ-022 Pipeline: S1 registers addr=(phase_acc+phase)[31:20] and env; S2 registers the signed 16-bit sine; S3 registers the output.
REQ-023 Latency SHALL be 3 clk from phase_acc/env to dac_data.
REQ-024 Sine SHALL use a 1024-entry quarter-wave table with quadrant folding: addr[11:10] is the quadrant, range ±32767, and the table SHALL never produce -32768.
REQ-025 Output SHALL be dac_data=(sine * {1'b0,env})[31:18], signed 16x17 with truncation; range -8192..8191.
REQ-026 dac_valid SHALL be busy delayed 3 clk; when dac_valid=0, dac_data SHALL be 0.
REQ-027 amp=0 SHALL still run the FSM and raise dac_valid, with dac_data=0.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE; phase_acc, env, latched config, pipeline registers, dac_data, dac_valid, tx_gate, busy and done SHALL all be 0.
REQ-029 Reset mid-pulse SHALL abort with no done strobe; operation resumes on the first edge after release.

Structure
REQ-030 Package nmr_gen_pkg SHALL hold the state encoding, LUT_ADDR_W=10, SINE_W=16, DAC_W=14 and PIPE_LAT=3.
REQ-031 Sub-module nmr_sine_lut SHALL contain the quarter-wave ROM plus folding, with 1-cycle registered output (S2).

Verification
REQ-032 freq=2^30, amp=0xFFFF, step=0, phase=0, en_gen high 8 clk -> from 3 clk after busy rises, dac_data = 0, 8191, 0, -8192 repeating.
REQ-033 amp=0x1000, step=0x0400, en_gen high 10 clk -> env 0x400, 0x800, 0xC00, 0x1000 then HOLD; after en_gen falls, env 0xC00, 0x800, 0x400, 0, with done on the IDLE edge.
REQ-034 en_gen falls when env=0x800 in RAMP_UP -> RAMP_DOWN next cycle, env 0x400 then 0; HOLD never entered.
REQ-035 rst raised in HOLD -> all outputs 0 in the same cycle with no clock edge, no done strobe.
REQ-036 phase=2^30, freq changed mid-pulse -> first valid sample 8191 and the original frequency is kept.
REQ-037 amp=0, step=5 -> dac_valid high, dac_data all 0, done one cycle after en_gen falls.
